// File: rtl/cpu_6502_sequencer.sv
// rtl/cpu_6502_sequencer.sv - 6502 micro-PC sequencer; optional macro CPU_6502_INT_SYNC_EN adds 2-flop IRQ/NMI synchronisers
package cpu_6502_pkg;

    typedef enum logic [3:0] {
        START         = 4'd0,
        NOP           = 4'd1,
        MICRO_EXECUTE = 4'd2,
        LOAD          = 4'd3,
        STORE         = 4'd4,
        READ_ADDR_LO  = 4'd5,
        READ_ADDR_HI  = 4'd6,
        PUSH_PCH      = 4'd7,
        PUSH_PCL      = 4'd8,
        PUSH_P        = 4'd9,
        VECTOR_LO     = 4'd10,
        VECTOR_HI     = 4'd11,
        ALU_OP        = 4'd12,
        BRANCH        = 4'd13,
        PULL          = 4'd14,
        JUMP          = 4'd15
    } microinstruction_t;

endpackage

module cpu_6502_sequencer
    import cpu_6502_pkg::*;
#(
    parameter int          MAX_CYCLES   = 8,
    parameter logic [7:0]  RESET_OPCODE = 8'hEA,
    localparam int         CW           = $clog2(MAX_CYCLES)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rdy,
    input  logic [7:0]        i_data,
    input  logic              i_irq_n,
    input  logic              i_nmi_n,
    input  logic              i_flag_i,
    input  microinstruction_t i_next_microinstruction,
    output microinstruction_t o_current_microinstruction,
    output logic [7:0]        o_current_instruction,
    output logic              o_init,
    output logic              o_handle_irq,
    output logic [1:0]        o_vector,
    output logic              o_sync,
    output logic [CW-1:0]     o_cycle,
    output logic              o_fault
);

    localparam logic [1:0] VEC_IRQ   = 2'b00;
    localparam logic [1:0] VEC_NMI   = 2'b01;
    localparam logic [1:0] VEC_RESET = 2'b10;

    logic irq_n_eff;
    logic nmi_n_eff;

`ifdef CPU_6502_INT_SYNC_EN
    logic [1:0] irq_sync;
    logic [1:0] nmi_sync;

    // Two-flop synchronisers for the asynchronous interrupt pins, idle-high.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            irq_sync <= 2'b11;
            nmi_sync <= 2'b11;
        end else begin
            irq_sync <= {irq_sync[0], i_irq_n};
            nmi_sync <= {nmi_sync[0], i_nmi_n};
        end
    end

    assign irq_n_eff = irq_sync[1];
    assign nmi_n_eff = nmi_sync[1];
`else
    assign irq_n_eff = i_irq_n;
    assign nmi_n_eff = i_nmi_n;
`endif

    microinstruction_t upc_q, upc_d;
    logic [7:0]        instr_q, instr_d;
    logic              init_q, init_d;
    logic              handle_irq_q, handle_irq_d;
    logic [1:0]        vector_q, vector_d;
    logic [CW-1:0]     cycle_q, cycle_d;
    logic              fault_q, fault_d;
    logic              nmi_pending_q, nmi_pending_d;
    logic              nmi_prev_q;

    logic              nmi_fall;
    logic              nmi_take;
    logic              fault_hit;

    // Sequencing state register; everything aborts to its reset value on i_reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            upc_q         <= START;
            instr_q       <= RESET_OPCODE;
            init_q        <= 1'b1;
            handle_irq_q  <= 1'b0;
            vector_q      <= VEC_RESET;
            cycle_q       <= '0;
            fault_q       <= 1'b0;
            nmi_pending_q <= 1'b0;
            nmi_prev_q    <= 1'b1;
        end else begin
            upc_q         <= upc_d;
            instr_q       <= instr_d;
            init_q        <= init_d;
            handle_irq_q  <= handle_irq_d;
            vector_q      <= vector_d;
            cycle_q       <= cycle_d;
            fault_q       <= fault_d;
            nmi_pending_q <= nmi_pending_d;
            nmi_prev_q    <= nmi_n_eff;
        end
    end

    // Next-state: fault recovery beats the normal step; boundary handles opcode latch and interrupt entry.
    always_comb begin
        upc_d        = upc_q;
        instr_d      = instr_q;
        init_d       = init_q;
        handle_irq_d = handle_irq_q;
        vector_d     = vector_q;
        cycle_d      = cycle_q;
        fault_d      = fault_q;
        nmi_take     = 1'b0;

        nmi_fall  = nmi_prev_q & ~nmi_n_eff;
        fault_hit = i_rdy &&
                    (((upc_q != START) && (upc_q != NOP) && (i_next_microinstruction == NOP)) ||
                     ((cycle_q == CW'(MAX_CYCLES - 1)) && (i_next_microinstruction != START)));

        if (fault_hit) begin
            upc_d        = START;
            instr_d      = RESET_OPCODE;
            init_d       = 1'b0;
            handle_irq_d = 1'b0;
            cycle_d      = '0;
            fault_d      = 1'b1;
        end else if (i_rdy) begin
            upc_d   = i_next_microinstruction;
            cycle_d = (i_next_microinstruction == START) ? '0 : cycle_q + CW'(1);
            if (upc_q == MICRO_EXECUTE) begin
                init_d = 1'b0;
                if (nmi_pending_q) begin
                    handle_irq_d = 1'b1;
                    vector_d     = VEC_NMI;
                    nmi_take     = 1'b1;
                end else if (!irq_n_eff && !i_flag_i) begin
                    handle_irq_d = 1'b1;
                    vector_d     = VEC_IRQ;
                end else begin
                    handle_irq_d = 1'b0;
                    instr_d      = i_data;
                    vector_d     = VEC_IRQ;
                end
            end
        end

        // A fresh edge arriving with the clear keeps the request pending.
        nmi_pending_d = nmi_fall | (nmi_pending_q & ~nmi_take);
    end

    assign o_current_microinstruction = upc_q;
    assign o_current_instruction      = instr_q;
    assign o_init                     = init_q;
    assign o_handle_irq               = handle_irq_q;
    assign o_vector                   = vector_q;
    assign o_cycle                    = cycle_q;
    assign o_fault                    = fault_q;
    assign o_sync                     = (upc_q == START) && !init_q && !handle_irq_q;

endmodule

// File: tb/tb_cpu_6502_sequencer.sv
// tb/tb_cpu_6502_sequencer.sv - self-checking bench for cpu_6502_sequencer
module tb_cpu_6502_sequencer;
    import cpu_6502_pkg::*;

    localparam int         MAX_CYCLES = 8;
    localparam logic [7:0] RST_OP     = 8'hEA;
`ifdef CPU_6502_INT_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b0;
    logic              i_rdy, i_irq_n, i_nmi_n, i_flag_i;
    logic [7:0]        i_data;
    microinstruction_t i_next_microinstruction;
    microinstruction_t o_current_microinstruction;
    logic [7:0]        o_current_instruction;
    logic              o_init, o_handle_irq, o_sync, o_fault;
    logic [1:0]        o_vector;
    logic [2:0]        o_cycle;

    cpu_6502_sequencer #(.MAX_CYCLES(MAX_CYCLES), .RESET_OPCODE(RST_OP)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_rdy(i_rdy), .i_data(i_data),
        .i_irq_n(i_irq_n), .i_nmi_n(i_nmi_n), .i_flag_i(i_flag_i),
        .i_next_microinstruction(i_next_microinstruction),
        .o_current_microinstruction(o_current_microinstruction),
        .o_current_instruction(o_current_instruction),
        .o_init(o_init), .o_handle_irq(o_handle_irq), .o_vector(o_vector),
        .o_sync(o_sync), .o_cycle(o_cycle), .o_fault(o_fault)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;

    microinstruction_t m_upc;
    logic [7:0]        m_instr;
    bit                m_init, m_hirq, m_fault, m_pend, m_nmi_prev;
    logic [1:0]        m_vec;
    int                m_cycle;
    bit [1:0]          m_irq_pipe, m_nmi_pipe;

    bit                force_en = 1'b0;
    microinstruction_t force_val = NOP;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_upc = START; m_instr = RST_OP; m_init = 1; m_hirq = 0; m_vec = 2'b10;
        m_cycle = 0; m_fault = 0; m_pend = 0; m_nmi_prev = 1;
        m_irq_pipe = 2'b11; m_nmi_pipe = 2'b11;
    endtask

    // Microcode ROM stand-in: interrupt/init chain, NOP, or a one-step load.
    function automatic microinstruction_t rom_next();
        case (m_upc)
            START:         return (m_init || m_hirq) ? PUSH_PCH : ((m_instr == 8'hEA) ? NOP : LOAD);
            PUSH_PCH:      return PUSH_PCL;
            PUSH_PCL:      return PUSH_P;
            PUSH_P:        return VECTOR_LO;
            VECTOR_LO:     return VECTOR_HI;
            VECTOR_HI:     return MICRO_EXECUTE;
            NOP, LOAD:     return MICRO_EXECUTE;
            default:       return START;
        endcase
    endfunction

    // Reference behaviour for one rising edge, from the pre-edge inputs.
    task automatic model_clock();
        bit irq_seen, nmi_seen, fall, take, flt;
`ifdef CPU_6502_INT_SYNC_EN
        irq_seen = m_irq_pipe[1];
        nmi_seen = m_nmi_pipe[1];
        m_irq_pipe = {m_irq_pipe[0], i_irq_n};
        m_nmi_pipe = {m_nmi_pipe[0], i_nmi_n};
`else
        irq_seen = i_irq_n;
        nmi_seen = i_nmi_n;
`endif
        fall = m_nmi_prev && !nmi_seen;
        take = 0;
        flt = i_rdy && ((m_upc != START && m_upc != NOP && i_next_microinstruction == NOP) ||
                        (m_cycle == MAX_CYCLES - 1 && i_next_microinstruction != START));
        if (flt) begin
            m_upc = START; m_instr = RST_OP; m_hirq = 0; m_cycle = 0; m_fault = 1; m_init = 0;
        end else if (i_rdy) begin
            if (m_upc == MICRO_EXECUTE) begin
                m_init = 0;
                if (m_pend) begin
                    m_hirq = 1; m_vec = 2'b01; take = 1;
                end else if (!irq_seen && !i_flag_i) begin
                    m_hirq = 1; m_vec = 2'b00;
                end else begin
                    m_hirq = 0; m_instr = i_data; m_vec = 2'b00;
                end
            end
            m_cycle = (i_next_microinstruction == START) ? 0 : m_cycle + 1;
            m_upc = i_next_microinstruction;
        end
        m_pend = fall || (m_pend && !take);
        m_nmi_prev = nmi_seen;
    endtask

    task automatic check_all();
        chk("upc",    32'(o_current_microinstruction), 32'(m_upc));
        chk("instr",  32'(o_current_instruction),      32'(m_instr));
        chk("init",   32'(o_init),                     32'(m_init));
        chk("hirq",   32'(o_handle_irq),               32'(m_hirq));
        chk("vector", 32'(o_vector),                   32'(m_vec));
        chk("sync",   32'(o_sync),                     32'(m_upc == START && !m_init && !m_hirq));
        chk("cycle",  32'(o_cycle),                    32'(m_cycle));
        chk("fault",  32'(o_fault),                    32'(m_fault));
    endtask

    task automatic step();
        i_next_microinstruction = force_en ? force_val : rom_next();
        @(posedge i_clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic run_until(input microinstruction_t target, input int budget);
        int n = 0;
        while (m_upc != target && n < budget) begin
            step();
            n++;
        end
        if (m_upc != target) begin
            total++;
            bad++;
            $error("FAIL timeout waiting for %0d observed=%0d", target, m_upc);
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    initial begin
        i_rdy = 1; i_irq_n = 1; i_nmi_n = 1; i_flag_i = 1; i_data = 8'hEA;
        i_next_microinstruction = START;
        #1;
        do_reset();
        chk("rst_vector", 32'(o_vector), 32'h2);

        // post-reset init chain then first opcode fetch
        i_data = 8'hA9;
        run_until(MICRO_EXECUTE, 20);
        chk("init_chain_init", 32'(o_init), 32'h1);
        chk("init_chain_vec", 32'(o_vector), 32'h2);
        step();
        chk("first_op", 32'(o_current_instruction), 32'hA9);
        chk("first_init", 32'(o_init), 32'h0);
        chk("first_sync", 32'(o_sync), 32'h1);
        chk("first_cycle", 32'(o_cycle), 32'h0);

        // NOP with a 3-cycle RDY stall in its NOP step
        i_data = 8'hEA;
        run_until(MICRO_EXECUTE, 20);
        step();
        step();
        i_rdy = 0;
        repeat (3) begin
            step();
            chk("stall_upc", 32'(o_current_microinstruction), 32'(NOP));
            chk("stall_cycle", 32'(o_cycle), 32'h1);
        end
        i_rdy = 1;
        step();
        chk("nop_exec_cycle", 32'(o_cycle), 32'h2);

        // masked IRQ, then unmasked IRQ
        i_irq_n = 0; i_flag_i = 1; i_data = 8'hA9;
        run_until(MICRO_EXECUTE, 20);
        step();
        chk("irq_masked", 32'(o_handle_irq), 32'h0);
        i_flag_i = 0; i_data = 8'h55;
        run_until(MICRO_EXECUTE, 20);
        step();
        chk("irq_taken", 32'(o_handle_irq), 32'h1);
        chk("irq_vec", 32'(o_vector), 32'h0);
        chk("irq_instr_hold", 32'(o_current_instruction), 32'hA9);
        i_flag_i = 1; i_irq_n = 1; i_data = 8'hEA;
        run_until(MICRO_EXECUTE, 20);
        step();

        // NMI and IRQ in the same instruction: NMI first, IRQ next
        i_nmi_n = 0; i_irq_n = 0; i_flag_i = 0;
        i_rdy = 0;
        repeat (3) step();
        i_rdy = 1;
        run_until(MICRO_EXECUTE, 20);
        step();
        chk("nmi_first_vec", 32'(o_vector), 32'h1);
        chk("nmi_first_hirq", 32'(o_handle_irq), 32'h1);
        run_until(MICRO_EXECUTE, 20);
        step();
        chk("irq_second_vec", 32'(o_vector), 32'h0);
        chk("irq_second_hirq", 32'(o_handle_irq), 32'h1);
        i_irq_n = 1; i_flag_i = 1; i_nmi_n = 1; i_data = 8'hA9;
        run_until(MICRO_EXECUTE, 20);
        step();

        // NMI edge during a stall at the boundary: one cycle too early, then just in time
        run_until(MICRO_EXECUTE, 20);
        i_rdy = 0; i_nmi_n = 0;
        repeat (SYNC_LAT) step();
        i_rdy = 1; i_data = 8'hEA;
        step();
        chk("nmi_early", 32'(o_handle_irq), 32'h0);
        i_nmi_n = 1;
        run_until(MICRO_EXECUTE, 20);
        step();
        chk("nmi_late_vec", 32'(o_vector), 32'h1);
        i_data = 8'hA9;
        run_until(MICRO_EXECUTE, 20);
        step();
        run_until(MICRO_EXECUTE, 20);
        i_rdy = 0; i_nmi_n = 0;
        repeat (SYNC_LAT + 1) step();
        i_rdy = 1;
        step();
        chk("nmi_on_time_hirq", 32'(o_handle_irq), 32'h1);
        chk("nmi_on_time_vec", 32'(o_vector), 32'h1);
        i_nmi_n = 1; i_data = 8'hA9;
        run_until(MICRO_EXECUTE, 20);
        step();

        // illegal NOP after LOAD
        run_until(LOAD, 20);
        force_en = 1; force_val = NOP;
        step();
        force_en = 0;
        chk("fault_a", 32'(o_fault), 32'h1);
        chk("fault_a_upc", 32'(o_current_microinstruction), 32'(START));
        chk("fault_a_instr", 32'(o_current_instruction), 32'hEA);
        repeat (10) step();
        chk("fault_sticky", 32'(o_fault), 32'h1);

        // asynchronous reset in mid-instruction
        step();
        #2;
        do_reset();
        chk("rst_clears_fault", 32'(o_fault), 32'h0);

        // ROM never returns START: fault at cycle 7, also ends init
        force_en = 1; force_val = PUSH_PCH;
        repeat (7) step();
        chk("cycle_max", 32'(o_cycle), 32'h7);
        chk("no_fault_yet", 32'(o_fault), 32'h0);
        step();
        force_en = 0;
        chk("fault_b", 32'(o_fault), 32'h1);
        chk("fault_b_cycle", 32'(o_cycle), 32'h0);
        chk("fault_b_init", 32'(o_init), 32'h0);

        // randomised traffic against the reference model
        do_reset();
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) do_reset();
            i_rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       i_data = 8'hEA;
                1:       i_data = 8'hA9;
                default: i_data = 8'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) i_irq_n = ~i_irq_n;
            if ($urandom_range(0, 7) == 0) i_flag_i = ~i_flag_i;
            if ($urandom_range(0, 11) == 0) i_nmi_n = ~i_nmi_n;
            force_en = (m_upc == LOAD) && ($urandom_range(0, 299) == 0);
            force_val = NOP;
            step();
        end
        force_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
